// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares one N-bit load-enabled register among R requesters. Every write is an
// atomic, round-robin arbitrated load lasting one LOAD cycle. The arbiter
// drives the register's load strobe and data input. It also reports the last
// writer and keeps a saturating count of completed writes.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req          per-requester write request, bit i = requester i
//   req_data     requester i data on bits [i*N +: N]
//   grant        one-hot acknowledge, high during the LOAD cycle of the winner
//   load_signal  load strobe to the shared register
//   data_input   data to the shared register (holds its value while idle)
//   last_writer  index of the most recently completed writer
//   write_count  saturating count of completed writes
//   busy         high while in LOAD
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int N  = 64,
    parameter int R  = 4,
    parameter int RW = $clog2(R),
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [R-1:0]    req,
    input  logic [R*N-1:0]  req_data,
    output logic [R-1:0]    grant,
    output logic            load_signal,
    output logic [N-1:0]    data_input,
    output logic [RW-1:0]   last_writer,
    output logic [CW-1:0]   write_count,
    output logic            busy
);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   ptr_r;
    logic [RW-1:0]   owner_r;
    logic [N-1:0]    data_r;
    logic [R-1:0]    grant_r;
    logic            load_signal_r;
    logic [N-1:0]    data_input_r;
    logic [RW-1:0]   last_writer_r;
    logic [CW-1:0]   write_count_r;
    logic            busy_r;

    logic            found_s;
    logic [RW-1:0]   winner_s;
    logic [N-1:0]    winner_data_s;
    logic [R-1:0]    winner_onehot_s;
    logic [RW-1:0]   next_ptr_s;
    int              idx_s;

    // Round-robin pick: first requester found scanning from ptr upward, modulo R.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {RW{1'b0}};
        idx_s    = 0;
        for (int k = 0; k < R; k++) begin
            idx_s = int'(ptr_r) + k;
            if (idx_s >= R) begin
                idx_s = idx_s - R;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                found_s  = 1'b1;
                winner_s = RW'(idx_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Winner's data word and its one-hot grant pattern.
    always_comb begin
        winner_data_s   = req_data[int'(winner_s)*N +: N];
        winner_onehot_s = {{(R-1){1'b0}}, 1'b1} << winner_s;
    end

    // Pointer after a completed write: one past the owner, wrapping at R-1.
    always_comb begin
        if (owner_r == RW'(R-1)) begin
            next_ptr_s = {RW{1'b0}};
        end else begin
            next_ptr_s = owner_r + RW'(1);
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ARB;
            ptr_r         <= {RW{1'b0}};
            owner_r       <= {RW{1'b0}};
            data_r        <= {N{1'b0}};
            grant_r       <= {R{1'b0}};
            load_signal_r <= 1'b0;
            data_input_r  <= {N{1'b0}};
            last_writer_r <= {RW{1'b0}};
            write_count_r <= {CW{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ARB: begin
                    if (found_s) begin
                        // Capture commits the request; later changes to req
                        // or req_data do not affect this write.
                        owner_r       <= winner_s;
                        data_r        <= winner_data_s;
                        grant_r       <= winner_onehot_s;
                        load_signal_r <= 1'b1;
                        data_input_r  <= winner_data_s;
                        busy_r        <= 1'b1;
                        state_r       <= LOAD;
                    end else begin
                        grant_r       <= {R{1'b0}};
                        load_signal_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ARB;
                    end
                end
                LOAD: begin
                    // The register samples data_input at this edge.
                    last_writer_r <= owner_r;
                    if (write_count_r != {CW{1'b1}}) begin
                        write_count_r <= write_count_r + CW'(1);
                    end else begin
                        write_count_r <= write_count_r;
                    end
                    ptr_r         <= next_ptr_s;
                    grant_r       <= {R{1'b0}};
                    load_signal_r <= 1'b0;
                    data_input_r  <= data_r;
                    busy_r        <= 1'b0;
                    state_r       <= ARB;
                end
                default: begin
                    grant_r       <= {R{1'b0}};
                    load_signal_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= ARB;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign load_signal = load_signal_r;
    assign data_input  = data_input_r;
    assign last_writer = last_writer_r;
    assign write_count = write_count_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for reg_write_arbiter (N=64, R=4). A second instance with
// CW=2 shares the same stimulus and is used for write-counter saturation.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int N  = 64;
    localparam int R  = 4;
    localparam int RW = 2;

    logic            clk;
    logic            reset;
    logic [R-1:0]    req;
    logic [R*N-1:0]  req_data;

    logic [R-1:0]    grant;
    logic            load_signal;
    logic [N-1:0]    data_input;
    logic [RW-1:0]   last_writer;
    logic [15:0]     write_count;
    logic            busy;

    logic [R-1:0]    s_grant;
    logic            s_load_signal;
    logic [N-1:0]    s_data_input;
    logic [RW-1:0]   s_last_writer;
    logic [1:0]      s_write_count;
    logic            s_busy;

    int vectors;
    int miscompares;

    reg_write_arbiter #(.N(N), .R(R), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .load_signal(load_signal), .data_input(data_input),
        .last_writer(last_writer), .write_count(write_count), .busy(busy)
    );

    reg_write_arbiter #(.N(N), .R(R), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(s_grant), .load_signal(s_load_signal), .data_input(s_data_input),
        .last_writer(s_last_writer), .write_count(s_write_count), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = 4'b1111;
        req_data = {R*N{1'b1}};
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({grant, load_signal, busy, last_writer, write_count} !== 25'd0 || data_input !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d: grant=%b load=%b busy=%b lw=%0d wc=%0d din=%h, want all zero",
                         c, grant, load_signal, busy, last_writer, write_count, data_input);
            end
        end
        reset = 1'b0;
        req   = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (grant !== 4'b0000 || load_signal !== 1'b0 || write_count !== 16'd0 || last_writer !== 2'd0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle cyc=%0d: grant=%b load=%b wc=%0d lw=%0d busy=%b, want 0000 0 0 0 0",
                         c, grant, load_signal, write_count, last_writer, busy);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req_data = '0;
        req_data[2*N +: N] = 64'hDEADBEEF_00000002;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0100 || load_signal !== 1'b1 || busy !== 1'b1 || data_input !== 64'hDEADBEEF_00000002) begin
            miscompares++;
            $display("FAIL single_load: grant=%b load=%b busy=%b din=%h, want 0100 1 1 deadbeef00000002",
                     grant, load_signal, busy, data_input);
        end
        tick();
        vectors++;
        if (last_writer !== 2'd2 || write_count !== 16'd1 || grant !== 4'b0000 || load_signal !== 1'b0 ||
            data_input !== 64'hDEADBEEF_00000002) begin
            miscompares++;
            $display("FAIL single_done: lw=%0d wc=%0d grant=%b load=%b din=%h, want 2 1 0000 0 deadbeef00000002",
                     last_writer, write_count, grant, load_signal, data_input);
        end
        // ptr is now 3: requesters 0,1,3 all asking must pick 3.
        req = 4'b1011;
        tick();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL ptr_after_single: grant=%b, want 1000", grant);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [R-1:0] exp_g;
        do_reset();
        for (int i = 0; i < R; i++) req_data[i*N +: N] = 64'hA5A5_0000_0000_0010 + 64'(i);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_g = (c % 2 == 0) ? (4'b0001 << (c / 2)) : 4'b0000;
            vectors++;
            if (grant !== exp_g) begin
                miscompares++;
                $display("FAIL rr_grant cyc=%0d: grant=%b, want %b", c, grant, exp_g);
            end
        end
        req = 4'b0000;
        vectors++;
        if (write_count !== 16'd4 || last_writer !== 2'd3 || data_input !== 64'hA5A5_0000_0000_0013) begin
            miscompares++;
            $display("FAIL rr_end: wc=%0d lw=%0d din=%h, want 4 3 a5a5000000000013",
                     write_count, last_writer, data_input);
        end
    endtask

    task automatic test_priority_rotation();
        do_reset();
        req = 4'b0010;
        tick();
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL rot_first: grant=%b, want 0010", grant);
        end
        req = 4'b0011;
        tick();
        tick();
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rot_wrap: grant=%b, want 0001", grant);
        end
        tick();
        tick();
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL rot_back: grant=%b, want 0010", grant);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_committed_request();
        do_reset();
        req_data = '0;
        req_data[1*N +: N] = 64'h1;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        req_data[1*N +: N] = 64'h2;
        vectors++;
        if (grant !== 4'b0010 || data_input !== 64'h1) begin
            miscompares++;
            $display("FAIL commit_load: grant=%b din=%h, want 0010 1", grant, data_input);
        end
        tick();
        vectors++;
        if (data_input !== 64'h1 || write_count !== 16'd1 || last_writer !== 2'd1) begin
            miscompares++;
            $display("FAIL commit_done: din=%h wc=%0d lw=%0d, want 1 1 1", data_input, write_count, last_writer);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        req_data = '0;
        req_data[0*N +: N] = 64'h1111;
        req_data[2*N +: N] = 64'h2222;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0100 || load_signal !== 1'b1 || write_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midload_pre: grant=%b load=%b wc=%0d, want 0100 1 1", grant, load_signal, write_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({grant, load_signal, busy, last_writer, write_count} !== 25'd0 || data_input !== 64'd0) begin
            miscompares++;
            $display("FAIL midload_reset: grant=%b load=%b busy=%b lw=%0d wc=%0d din=%h, want all zero",
                     grant, load_signal, busy, last_writer, write_count, data_input);
        end
        // ptr back at 0 after reset.
        req = 4'b1111;
        tick();
        req = 4'b0000;
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midload_ptr: grant=%b, want 0001", grant);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            req = 4'b0001;
            tick();
            req = 4'b0000;
            tick();
            exp_s = (w >= 3) ? 2'd3 : 2'(w);
            vectors++;
            if (s_write_count !== exp_s || write_count !== 16'(w)) begin
                miscompares++;
                $display("FAIL sat_count w=%0d: cw2=%0d cw16=%0d, want %0d %0d", w, s_write_count, write_count, exp_s, w);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = 4'b0000;
        req_data    = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_priority_rotation();
        test_committed_request();
        test_reset_mid_load();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
